// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and shifts
// them out one bit per enabled clock, with a one-word holding buffer for gapless streaming.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic             hold_valid;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg_next;
  logic             cur_bit;
  logic             accept;

  // in_ready comes straight from the hold_valid flop, so in_valid never reaches it
  assign in_ready   = ~hold_valid;
  assign accept     = in_valid & ~hold_valid;
  assign cur_bit    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign sreg_next  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign dout       = (state == SHIFT) ? cur_bit : IDLE_BIT;
  assign dout_valid = (state == SHIFT);
  assign busy       = (state == SHIFT) | hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      cnt        <= '0;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg  <= in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (en && (cnt == LAST)) begin
            words_sent <= words_sent + 16'd1;
            // buffered word first; otherwise bypass a word arriving on this very edge
            if (hold_valid) begin
              sreg       <= hold;
              hold_valid <= 1'b0;
              cnt        <= '0;
            end else if (accept) begin
              sreg <= in_data;
              cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (en) begin
              sreg <= sreg_next;
              cnt  <= cnt + CW'(1);
            end
            if (accept) begin
              hold       <= in_data;
              hold_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: two instances (MSB-first/idle 0 and LSB-first/idle 1)
// share stimulus; expected bit streams are built from accepted words and popped by a monitor.
module tb_bit_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             en = 1'b1;
  logic             dout_a  [2];
  logic             valid_a [2];
  logic             ready_a [2];
  logic             busy_a  [2];
  logic [15:0]      ws_a    [2];

  bit               exp_q [2][$];
  int               bits_done [2];
  int               sent [2];
  int               pass_cnt = 0;
  int               total_cnt = 0;
  bit               mon_on = 1'b0;
  int               en_mode = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ready_a[0]),
    .en(en), .dout(dout_a[0]), .dout_valid(valid_a[0]), .busy(busy_a[0]), .words_sent(ws_a[0]));

  bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ready_a[1]),
    .en(en), .dout(dout_a[1]), .dout_valid(valid_a[1]), .busy(busy_a[1]), .words_sent(ws_a[1]));

  task automatic check(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s[%0d] t=%0t actual=%0h required=%0h", nm, id, $time, act, req);
  endtask

  // expected serial order comes from the word value and the instance's bit order
  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int id = 0; id < 2; id++)
      for (int i = 0; i < WIDTH; i++)
        exp_q[id].push_back(id == 0 ? w[WIDTH-1-i] : w[i]);
  endtask

  task automatic clear_model();
    for (int id = 0; id < 2; id++) begin
      exp_q[id].delete();
      bits_done[id] = 0;
      sent[id] = 0;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (ready_a[0]) ok = 1'b1;
    end
    if (!ok) check(0, "accept_timeout", ready_a[0], 1);
    @(posedge clk);
    #1;
    if (ok) push_word(w);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0) done = 1'b1;
    end
    if (!done) check(0, "drain_timeout", exp_q[0].size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ~en;
        default: en = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: dout_valid must track pending expected bits exactly (latency 1, no gaps),
  // in_ready must drop only while a second word is buffered behind the current one.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && !rst) begin
        for (int id = 0; id < 2; id++) begin
          int n;
          n = exp_q[id].size();
          check(id, "in_ready", ready_a[id], (n <= WIDTH));
          check(id, "dout_valid", valid_a[id], (n > 0));
          check(id, "busy", busy_a[id], (n > 0));
          check(id, "words_sent", ws_a[id], sent[id] & 16'hFFFF);
          if (n > 0) begin
            check(id, "dout", dout_a[id], exp_q[id][0]);
            if (en) begin
              void'(exp_q[id].pop_front());
              bits_done[id]++;
              if (bits_done[id] % WIDTH == 0) sent[id]++;
            end
          end else begin
            check(id, "dout_idle", dout_a[id], (id == 0) ? 0 : 1);
          end
        end
      end
    end
  end

  initial begin
    clear_model();
    #2;
    for (int id = 0; id < 2; id++) begin
      check(id, "rst_dout", dout_a[id], (id == 0) ? 0 : 1);
      check(id, "rst_valid", valid_a[id], 0);
      check(id, "rst_ready", ready_a[id], 1);
      check(id, "rst_busy", busy_a[id], 0);
      check(id, "rst_words", ws_a[id], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    en_mode = 0;
    send(8'hA5);
    drain();

    send(8'h05);
    send(8'hA0);
    drain();

    en_mode = 1;
    send(8'hA5);
    drain();

    en_mode = 0;
    send(8'h3C);
    send(8'hC3);
    send(8'h01);
    drain();

    // reset mid-word while the holding buffer is occupied
    send(8'hF0);
    send(8'h0F);
    repeat (2) @(posedge clk);
    #3;
    mon_on = 1'b0;
    rst = 1'b1;
    #1;
    for (int id = 0; id < 2; id++) begin
      check(id, "midrst_dout", dout_a[id], (id == 0) ? 0 : 1);
      check(id, "midrst_valid", valid_a[id], 0);
      check(id, "midrst_ready", ready_a[id], 1);
      check(id, "midrst_busy", busy_a[id], 0);
      check(id, "midrst_words", ws_a[id], 0);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk);
    #1;
    send(8'h96);
    drain();

    en_mode = 2;
    for (int k = 0; k < 40; k++) begin
      send(WIDTH'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 12)) @(posedge clk);
      #1;
    end
    drain();
    en_mode = 0;
    for (int k = 0; k < 10; k++) send(WIDTH'($urandom));
    drain();

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
